// File: rtl/calc_pkg.sv
// Shared encodings for the keyboard calculator core: FSM states, operator codes,
// PS/2 set-2 key bytes and small decode helpers.
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    SECOND = 3'd2,
    EXEC   = 3'd3,
    CONV   = 3'd4,
    RESULT = 3'd5,
    ERROR  = 3'd6
  } state_t;

  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} op_t;

  localparam logic [7:0] KEY_0     = 8'h70;
  localparam logic [7:0] KEY_1     = 8'h69;
  localparam logic [7:0] KEY_2     = 8'h72;
  localparam logic [7:0] KEY_3     = 8'h7A;
  localparam logic [7:0] KEY_4     = 8'h6B;
  localparam logic [7:0] KEY_5     = 8'h73;
  localparam logic [7:0] KEY_6     = 8'h74;
  localparam logic [7:0] KEY_7     = 8'h6C;
  localparam logic [7:0] KEY_8     = 8'h75;
  localparam logic [7:0] KEY_9     = 8'h7D;
  localparam logic [7:0] KEY_PLUS  = 8'h79;
  localparam logic [7:0] KEY_MINUS = 8'h7B;
  localparam logic [7:0] KEY_MUL   = 8'h7C;
  localparam logic [7:0] KEY_DIV   = 8'h4A;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_DOT   = 8'h71;
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  // {valid, digit}
  function automatic logic [4:0] key_digit(input logic [7:0] code);
    case (code)
      KEY_0:   return 5'h10;
      KEY_1:   return 5'h11;
      KEY_2:   return 5'h12;
      KEY_3:   return 5'h13;
      KEY_4:   return 5'h14;
      KEY_5:   return 5'h15;
      KEY_6:   return 5'h16;
      KEY_7:   return 5'h17;
      KEY_8:   return 5'h18;
      KEY_9:   return 5'h19;
      default: return 5'h00;
    endcase
  endfunction

  // {valid, op}
  function automatic logic [2:0] key_op(input logic [7:0] code);
    case (code)
      KEY_PLUS:  return {1'b1, OP_ADD};
      KEY_MINUS: return {1'b1, OP_SUB};
      KEY_MUL:   return {1'b1, OP_MUL};
      KEY_DIV:   return {1'b1, OP_DIV};
      default:   return 3'b000;
    endcase
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one input bit per cycle, BIN_W cycles from start.
// done is high during the final iteration cycle; bcd holds the value afterwards.
module bin2bcd_seq #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [BIN_W-1:0]      bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CW = $clog2(BIN_W);

  logic [BIN_W-1:0]    sh;
  logic [CW-1:0]       cnt;
  logic                run;
  logic [4*DIGITS-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i+:4] >= 4'd5) adj[4*i+:4] = bcd[4*i+:4] + 4'd3;
  end

  assign done = run && (cnt == CW'(BIN_W-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
      run <= 1'b0;
      bcd <= '0;
    end else if (abort) begin
      run <= 1'b0;
      bcd <= '0;
    end else if (start) begin
      sh  <= bin;
      cnt <= '0;
      run <= 1'b1;
      bcd <= '0;
    end else if (run) begin
      // value stays below 10^DIGITS, so nothing is lost off the top nibble
      bcd <= {adj[4*DIGITS-2:0], sh[BIN_W-1]};
      sh  <= {sh[BIN_W-2:0], 1'b0};
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/calc_core_seq.sv
// Keyboard calculator core: PS/2 byte filter, operand entry, multi-cycle + - x /,
// and BCD conversion. Define CALC_CHAIN_EN to let an operator in RESULT chain the result.
module calc_core_seq
  import calc_pkg::*;
#(
  parameter int         DIGITS    = 6,
  parameter int         BIN_W     = 20,
  parameter logic [3:0] ERR_DIGIT = 4'hE
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iKEY_VALID,
  input  logic [7:0]           iKEY_CODE,
  output logic                 oBUSY,
  output logic [4*DIGITS-1:0]  oDISP_BCD,
  output logic                 oNEG,
  output logic                 oERR,
  output logic                 oREM_SEL,
  output logic [2:0]           oSTATE
);
  localparam int NW  = 4*DIGITS;
  localparam int CW  = $clog2(BIN_W);
  localparam int DCW = $clog2(DIGITS+1);
  localparam logic [BIN_W:0] LIMIT = (BIN_W+1)'(pow10(DIGITS));

  state_t state, state_n;
  op_t    op, op_n;
  logic   brk;
  logic [NW-1:0]    a_bcd, a_bcd_n, b_bcd, b_bcd_n, res_bcd, rem_bcd;
  logic [BIN_W-1:0] a_bin, a_bin_n, b_bin, b_bin_n, acc, acc_n, rem, rem_n;
  logic [DCW-1:0]   a_cnt, a_cnt_n, b_cnt, b_cnt_n;
  logic [CW-1:0]    cnt, cnt_n, bidx;
  logic             ovf, ovf_n, neg, neg_n, rem_sel, rem_sel_n;
  logic             conv_go, res_done, rem_done, new_a;
  logic [BIN_W:0]   sum, sh1, add1, rsh, rsub;

  logic       key_v, is_dig, is_op, is_ent, is_esc, is_dot;
  logic [4:0] dig;
  logic [2:0] opk;

  // break prefix swallows the following byte; extended prefix is transparent
  assign key_v  = iKEY_VALID && !brk && iKEY_CODE != KEY_BREAK && iKEY_CODE != KEY_EXT;
  assign dig    = key_digit(iKEY_CODE);
  assign opk    = key_op(iKEY_CODE);
  assign is_dig = key_v && dig[4];
  assign is_op  = key_v && opk[2];
  assign is_ent = key_v && iKEY_CODE == KEY_ENTER;
  assign is_esc = key_v && iKEY_CODE == KEY_ESC;
  assign is_dot = key_v && iKEY_CODE == KEY_DOT;
  assign bidx   = CW'(BIN_W-1) - cnt;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) brk <= 1'b0;
    else if (iKEY_VALID && iKEY_CODE != KEY_EXT)
      brk <= brk ? 1'b0 : (iKEY_CODE == KEY_BREAK);
  end

  function automatic logic [BIN_W-1:0] mac10(input logic [BIN_W-1:0] v, input logic [3:0] d);
    return (v << 3) + (v << 1) + BIN_W'(d);
  endfunction

  always_comb begin
    state_n = state;   op_n = op;
    a_bcd_n = a_bcd;   a_bin_n = a_bin;   a_cnt_n = a_cnt;
    b_bcd_n = b_bcd;   b_bin_n = b_bin;   b_cnt_n = b_cnt;
    acc_n = acc;       rem_n = rem;       cnt_n = cnt;
    ovf_n = ovf;       neg_n = neg;       rem_sel_n = rem_sel;
    conv_go = 1'b0;    new_a = 1'b0;
    sum = '0; sh1 = '0; add1 = '0; rsh = '0; rsub = '0;
    case (state)
      IDLE: if (is_dig) new_a = 1'b1;
      FIRST: begin
        if (is_dig && a_cnt < DCW'(DIGITS)) begin
          a_bcd_n = {a_bcd[NW-5:0], dig[3:0]};
          a_bin_n = mac10(a_bin, dig[3:0]);
          a_cnt_n = a_cnt + 1'b1;
        end else if (is_op) begin
          op_n = op_t'(opk[1:0]);
          b_bcd_n = '0; b_bin_n = '0; b_cnt_n = '0;
          state_n = SECOND;
        end
      end
      SECOND: begin
        if (is_op && b_cnt == '0) op_n = op_t'(opk[1:0]);
        else if (is_dig && b_cnt < DCW'(DIGITS)) begin
          b_bcd_n = {b_bcd[NW-5:0], dig[3:0]};
          b_bin_n = mac10(b_bin, dig[3:0]);
          b_cnt_n = b_cnt + 1'b1;
        end else if (is_ent && b_cnt != '0) begin
          cnt_n = '0; ovf_n = 1'b0; neg_n = 1'b0; rem_n = '0;
          acc_n = (op == OP_DIV) ? a_bin : '0;
          state_n = EXEC;
        end
      end
      EXEC: begin
        case (op)
          OP_ADD: begin
            sum = {1'b0, a_bin} + {1'b0, b_bin};
            if (sum >= LIMIT) state_n = ERROR;
            else begin
              acc_n = sum[BIN_W-1:0]; conv_go = 1'b1; state_n = CONV;
            end
          end
          OP_SUB: begin
            if (a_bin < b_bin) begin
              acc_n = b_bin - a_bin; neg_n = 1'b1;
            end else acc_n = a_bin - b_bin;
            conv_go = 1'b1; state_n = CONV;
          end
          OP_MUL: begin
            // MSB-first shift-add; any bit pushed past BIN_W is sticky overflow
            sh1   = {acc, 1'b0};
            add1  = {1'b0, sh1[BIN_W-1:0]} + (b_bin[bidx] ? {1'b0, a_bin} : '0);
            acc_n = add1[BIN_W-1:0];
            ovf_n = ovf | sh1[BIN_W] | add1[BIN_W];
            cnt_n = cnt + 1'b1;
            if (cnt == CW'(BIN_W-1)) begin
              cnt_n = '0;
              if (ovf_n || {1'b0, acc_n} >= LIMIT) state_n = ERROR;
              else begin conv_go = 1'b1; state_n = CONV; end
            end
          end
          OP_DIV: begin
            if (cnt == '0 && b_bin == '0) state_n = ERROR;
            else begin
              rsh  = {rem, acc[BIN_W-1]};
              rsub = rsh - {1'b0, b_bin};
              if (rsh >= {1'b0, b_bin}) begin
                rem_n = rsub[BIN_W-1:0]; acc_n = {acc[BIN_W-2:0], 1'b1};
              end else begin
                rem_n = rsh[BIN_W-1:0];  acc_n = {acc[BIN_W-2:0], 1'b0};
              end
              cnt_n = cnt + 1'b1;
              if (cnt == CW'(BIN_W-1)) begin
                cnt_n = '0; conv_go = 1'b1; state_n = CONV;
              end
            end
          end
          default: state_n = ERROR;
        endcase
      end
      CONV: if (res_done && rem_done) state_n = RESULT;
      RESULT: begin
        if (is_dig) new_a = 1'b1;
        else if (is_dot && op == OP_DIV) rem_sel_n = ~rem_sel;
`ifdef CALC_CHAIN_EN
        else if (is_op && !neg) begin
          a_bcd_n = res_bcd; a_bin_n = acc; a_cnt_n = DCW'(DIGITS);
          b_bcd_n = '0; b_bin_n = '0; b_cnt_n = '0;
          op_n = op_t'(opk[1:0]); rem_sel_n = 1'b0;
          state_n = SECOND;
        end
`endif
      end
      ERROR: if (is_dig) new_a = 1'b1;
      default: state_n = IDLE;
    endcase

    if (new_a) begin
      a_bcd_n = NW'(dig[3:0]); a_bin_n = BIN_W'(dig[3:0]); a_cnt_n = DCW'(1);
      b_bcd_n = '0; b_bin_n = '0; b_cnt_n = '0;
      neg_n = 1'b0; rem_sel_n = 1'b0;
      state_n = FIRST;
    end
    if (is_esc) begin
      state_n = IDLE; op_n = OP_ADD;
      a_bcd_n = '0; a_bin_n = '0; a_cnt_n = '0;
      b_bcd_n = '0; b_bin_n = '0; b_cnt_n = '0;
      acc_n = '0; rem_n = '0; cnt_n = '0;
      ovf_n = 1'b0; neg_n = 1'b0; rem_sel_n = 1'b0;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;  op <= OP_ADD;
      a_bcd <= '0; a_bin <= '0; a_cnt <= '0;
      b_bcd <= '0; b_bin <= '0; b_cnt <= '0;
      acc <= '0; rem <= '0; cnt <= '0;
      ovf <= 1'b0; neg <= 1'b0; rem_sel <= 1'b0;
    end else begin
      state <= state_n;  op <= op_n;
      a_bcd <= a_bcd_n; a_bin <= a_bin_n; a_cnt <= a_cnt_n;
      b_bcd <= b_bcd_n; b_bin <= b_bin_n; b_cnt <= b_cnt_n;
      acc <= acc_n; rem <= rem_n; cnt <= cnt_n;
      ovf <= ovf_n; neg <= neg_n; rem_sel <= rem_sel_n;
    end
  end

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_res_bcd (
    .clk(iCLK), .rst(iRST), .start(conv_go), .abort(is_esc),
    .bin(acc_n), .done(res_done), .bcd(res_bcd)
  );

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_rem_bcd (
    .clk(iCLK), .rst(iRST), .start(conv_go), .abort(is_esc),
    .bin(rem_n), .done(rem_done), .bcd(rem_bcd)
  );

  // EXEC/CONV keep showing B, the value on display when Enter was pressed
  always_comb begin
    oDISP_BCD = '0;
    case (state)
      FIRST:             oDISP_BCD = a_bcd;
      SECOND, EXEC, CONV: oDISP_BCD = b_bcd;
      RESULT:            oDISP_BCD = rem_sel ? rem_bcd : res_bcd;
      ERROR:             oDISP_BCD = {DIGITS{ERR_DIGIT}};
      default:           oDISP_BCD = '0;
    endcase
  end

  assign oBUSY    = (state == EXEC) || (state == CONV);
  assign oERR     = (state == ERROR);
  assign oNEG     = neg;
  assign oREM_SEL = rem_sel;
  assign oSTATE   = state;
endmodule

// File: tb/tb_calc_core_seq.sv
// Directed bench for calc_core_seq: key sequences with hand-computed display,
// flag, state and busy-length expectations (DIGITS=6, BIN_W=20).
module tb_calc_core_seq;
  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iKEY_VALID;
  logic [7:0]  iKEY_CODE;
  logic        oBUSY, oNEG, oERR, oREM_SEL;
  logic [23:0] oDISP_BCD;
  logic [2:0]  oSTATE;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 iCLK = ~iCLK;

  calc_core_seq #(.DIGITS(6), .BIN_W(20), .ERR_DIGIT(4'hE)) dut (
    .iCLK(iCLK), .iRST(iRST), .iKEY_VALID(iKEY_VALID), .iKEY_CODE(iKEY_CODE),
    .oBUSY(oBUSY), .oDISP_BCD(oDISP_BCD), .oNEG(oNEG), .oERR(oERR),
    .oREM_SEL(oREM_SEL), .oSTATE(oSTATE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; strobes one byte for exactly one clock
  task automatic key(input logic [7:0] c);
    iKEY_CODE  = c;
    iKEY_VALID = 1'b1;
    @(negedge iCLK);
    iKEY_VALID = 1'b0;
  endtask

  task automatic wait_busy(output int cyc);
    cyc = 0;
    while (oBUSY && cyc < 200) begin
      cyc++;
      @(negedge iCLK);
    end
  endtask

  initial begin
    iRST = 1'b1; iKEY_VALID = 1'b0; iKEY_CODE = 8'h00;
    repeat (2) @(negedge iCLK);
    chk("rst_state", 32'(oSTATE), 0);
    chk("rst_disp", 32'(oDISP_BCD), 0);
    chk("rst_flags", {oBUSY, oNEG, oERR, oREM_SEL}, 0);
    iRST = 1'b0;
    @(negedge iCLK);

    // 12 + 34
    key(8'h69); key(8'h72); key(8'h79); key(8'h7A); key(8'h6B);
    chk("add_second_state", 32'(oSTATE), 2);
    chk("add_second_disp", 32'(oDISP_BCD), 32'h34);
    key(8'h5A);
    wait_busy(n);
    chk("add_busy_len", n, 21);
    chk("add_state", 32'(oSTATE), 5);
    chk("add_disp", 32'(oDISP_BCD), 32'h46);
    chk("add_neg", 32'(oNEG), 0);

    // 5 - 8
    key(8'h73); key(8'h7B); key(8'h75); key(8'h5A);
    wait_busy(n);
    chk("sub_busy_len", n, 21);
    chk("sub_disp", 32'(oDISP_BCD), 32'h3);
    chk("sub_neg", 32'(oNEG), 1);
    key(8'h79);
    chk("sub_op_ignored", 32'(oSTATE), 5);

    // 100 / 7 = 14 r 2
    key(8'h69); key(8'h70); key(8'h70); key(8'h4A); key(8'h6C); key(8'h5A);
    wait_busy(n);
    chk("div_busy_len", n, 40);
    chk("div_quot", 32'(oDISP_BCD), 32'h14);
    chk("div_neg_cleared", 32'(oNEG), 0);
    key(8'h71);
    chk("div_rem", 32'(oDISP_BCD), 32'h2);
    chk("div_remsel", 32'(oREM_SEL), 1);
    key(8'h71);
    chk("div_quot_back", 32'(oDISP_BCD), 32'h14);
    chk("div_remsel_off", 32'(oREM_SEL), 0);

    // 999999 x 2 overflows
    repeat (6) key(8'h7D);
    key(8'h7C); key(8'h72); key(8'h5A);
    wait_busy(n);
    chk("mul_busy_len", n, 20);
    chk("mul_err", 32'(oERR), 1);
    chk("mul_err_disp", 32'(oDISP_BCD), 32'hEEEEEE);
    chk("mul_err_state", 32'(oSTATE), 6);
    key(8'h76);
    chk("esc_state", 32'(oSTATE), 0);
    chk("esc_disp", 32'(oDISP_BCD), 0);
    chk("esc_err", 32'(oERR), 0);

    // break / extended prefix filtering
    key(8'h69); key(8'hF0); key(8'h69); key(8'hE0);
    key(8'h72); key(8'hE0); key(8'hF0); key(8'h72);
    chk("filter_state", 32'(oSTATE), 1);
    chk("filter_disp", 32'(oDISP_BCD), 32'h12);

    // digit count saturates at 6
    key(8'h7A); key(8'h6B); key(8'h73); key(8'h74); key(8'h6C);
    chk("sat_disp", 32'(oDISP_BCD), 32'h123456);

    // Enter without B ignored; second operator replaces the first
    key(8'h79); key(8'h5A);
    chk("enter_noB_state", 32'(oSTATE), 2);
    chk("enter_noB_disp", 32'(oDISP_BCD), 0);
    key(8'h7B); key(8'h7A); key(8'h5A);
    wait_busy(n);
    chk("opreplace_disp", 32'(oDISP_BCD), 32'h123453);
    chk("opreplace_neg", 32'(oNEG), 0);

    // 4 / 0
    key(8'h6B); key(8'h4A); key(8'h70); key(8'h5A);
    wait_busy(n);
    chk("div0_busy_len", n, 1);
    chk("div0_err", 32'(oERR), 1);
    chk("div0_state", 32'(oSTATE), 6);
    key(8'h72);
    chk("err_digit_state", 32'(oSTATE), 1);
    chk("err_digit_disp", 32'(oDISP_BCD), 32'h2);

    // reset during the 5th EXEC cycle of a divide
    key(8'h76);
    key(8'h69); key(8'h70); key(8'h70); key(8'h4A); key(8'h6C); key(8'h5A);
    repeat (4) @(negedge iCLK);
    chk("mid_exec_state", 32'(oSTATE), 3);
    #2 iRST = 1'b1;
    #1;
    chk("mid_rst_state", 32'(oSTATE), 0);
    chk("mid_rst_disp", 32'(oDISP_BCD), 0);
    chk("mid_rst_flags", {oBUSY, oNEG, oERR, oREM_SEL}, 0);
    @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
    chk("post_rst_state", 32'(oSTATE), 0);

    // 2 + 3 after reset
    key(8'h72); key(8'h79); key(8'h7A); key(8'h5A);
    wait_busy(n);
    chk("recover_busy_len", n, 21);
    chk("recover_disp", 32'(oDISP_BCD), 32'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
